// File: rtl/tb_uart_pkg.sv
// ----------------------------------------------------------------------------
// tb_uart_pkg
// Shared definitions for the simulation-side UART monitor.
//   rx_state_t          : receiver FSM states
//   CLKS_PER_BIT_115200 : default bit period (115200 baud from a 50 MHz clock)
//   half_bit_load()     : bit-timer preload that puts the first sample at
//                         mid start bit, CLKS_PER_BIT/2 cycles after the edge
// ----------------------------------------------------------------------------
package tb_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    localparam int CLKS_PER_BIT_115200 = 434;

    // The bit timer fires when it reaches clks_per_bit-1. Preloading it with
    // clks_per_bit - clks_per_bit/2 makes the first fire land exactly
    // clks_per_bit/2 cycles after the start edge was seen.
    function automatic int half_bit_load(input int clks_per_bit);
        return clks_per_bit - (clks_per_bit / 2);
    endfunction

endpackage

// File: rtl/tb_uart_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_fifo
// First-word-fall-through FIFO; the head entry is visible on data whenever
// valid is high. Reused by any UART helper that needs byte buffering.
// Ports:
//   sim_clk, sim_rst : clock, asynchronous active-high reset
//   push, push_data  : write request and data (accepted if not full, or if
//                      a pop happens in the same cycle)
//   full             : no free entry
//   pop              : consume head when valid
//   valid, data      : head entry present / head entry value (0 when empty)
// ----------------------------------------------------------------------------
module tb_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             sim_clk,
    input  logic             sim_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are meaningful, and the output is forced to zero when
    // empty so stale contents never leak out after a reset.
    always_ff @(posedge sim_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign data = valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/tb_uart_monitor.sv
// ----------------------------------------------------------------------------
// tb_uart_monitor
// Simulation-side UART receiver (8N1, LSB first) watching the design's
// uart_tx line. Received bytes are buffered in a FWFT FIFO and presented on
// a valid/ready interface; framing errors and FIFO overflow are sticky flags.
// Ports:
//   sim_clk, sim_rst : clock, asynchronous active-high reset
//   uart_line        : serial input, idle high
//   rx_valid/rx_data : FIFO head present / head byte
//   rx_ready         : pop the head when rx_valid is high
//   frame_err        : sticky, a stop bit was sampled low
//   overflow         : sticky, a byte was dropped because the FIFO was full
//   byte_count       : bytes accepted into the FIFO (wraps)
// Build option: define TB_UART_MON_PRINT_EN to echo every accepted byte to
// the simulator console with $write (0x0A ends the line).
// ----------------------------------------------------------------------------
module tb_uart_monitor
    import tb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        sim_clk,
    input  logic        sim_rst,
    input  logic        uart_line,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic [31:0] byte_count
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LOAD = 16'(half_bit_load(CLKS_PER_BIT));

    logic        s_meta;
    logic        s_line;
    rx_state_t   state, state_n;
    logic [15:0] timer, timer_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic        tick;
    logic        push;
    logic        err_set;
    logic        fifo_full;
    logic        pop_fire;
    logic        accepted;
    logic        dropped;

    // Two-flop synchronizer; resets to the idle level so reset never looks
    // like a start edge.
    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            s_meta <= 1'b1;
            s_line <= 1'b1;
        end else begin
            s_meta <= uart_line;
            s_line <= s_meta;
        end
    end

    assign tick = (timer == BIT_LAST);

    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        timer_n   = tick ? '0 : timer + 16'd1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        push      = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (!s_line) begin
                    state_n = START;
                    timer_n = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    state_n   = s_line ? IDLE : DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n   = {s_line, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_line) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_set = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                timer_n = '0;
                if (s_line) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop_fire = rx_valid && rx_ready;
    assign accepted = push && (!fifo_full || pop_fire);
    assign dropped  = push && fifo_full && !pop_fire;

    tb_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sim_clk   (sim_clk),
        .sim_rst   (sim_rst),
        .push      (push),
        .push_data (shift),
        .full      (fifo_full),
        .pop       (rx_ready),
        .valid     (rx_valid),
        .data      (rx_data)
    );

    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else begin
            if (err_set)  frame_err  <= 1'b1;
            if (dropped)  overflow   <= 1'b1;
            if (accepted) byte_count <= byte_count + 32'd1;
        end
    end

`ifdef TB_UART_MON_PRINT_EN
    always @(posedge sim_clk) begin
        if (!sim_rst && accepted) begin
            if (shift == 8'h0A) begin
                $write("\n");
            end else begin
                $write("%c", shift);
            end
        end
    end
`else
    // Console echo disabled: no display side effects.
`endif

endmodule
